// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port, with a retired-instruction counter and a bus watchdog.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The counter value seen on the last permitted wait cycle of one access.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       mem_phase;
  logic       expire;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R_TYPE) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  assign state     = st;
  assign mem_phase = (st == S_FETCH) || (st == S_MEM);
  assign expire    = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

  // Strobes are pure decode of the current state; holding reset low silences all of them.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    if (reset) begin
      case (st)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: begin
          alu_src_b = uses_imm(opcode);
          if (opcode == OP_BRANCH) begin
            pc_write = 1'b1;
            pc_sel   = alu_zero;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          alu_src_b    = 1'b1;
          mem_we       = (opcode == OP_STORE);
          pc_write     = mem_ready && (opcode == OP_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OP_LOAD);
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // pc_write marks retirement, so instret counts exactly the cycles that pulse it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= S_FETCH;
      wait_cnt  <= 8'd0;
      instret   <= 32'd0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (pc_write)
        instret <= instret + 32'd1;
      wait_cnt <= (mem_phase && !mem_ready && !expire) ? wait_cnt + 8'd1 : 8'd0;
      if (expire) begin
        bus_error <= 1'b1;
        st        <= S_TRAP;
      end else begin
        case (st)
          S_FETCH: if (mem_ready) st <= S_DECODE;
          S_DECODE: begin
            if (is_supported(opcode)) begin
              st <= S_EXEC;
            end else begin
              illegal <= 1'b1;
              st      <= S_TRAP;
            end
          end
          S_EXEC: begin
            case (opcode)
              OP_R_TYPE, OP_IMM: st <= S_WB;
              OP_LOAD, OP_STORE: st <= S_MEM;
              OP_BRANCH:         st <= S_FETCH;
              default: begin
                illegal <= 1'b1;
                st      <= S_TRAP;
              end
            endcase
          end
          S_MEM: if (mem_ready) st <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
          S_WB:  st <= S_FETCH;
          default: st <= S_TRAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction runs checked every cycle against
// an instruction-level model, plus literal expectations from hand-timed sequences.
module tb_multicycle_ctrl;

  localparam int MW = 4;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [31:0] PRELOAD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = OP_I;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel;
  logic        alu_src_b, reg_write, mem_to_reg, illegal, bus_error;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [8:0]  dut_vec;

  multicycle_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .state(state), .instret(instret), .illegal(illegal),
    .bus_error(bus_error)
  );

  assign dut_vec = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel,
                    alu_src_b, reg_write, mem_to_reg};

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_L, OP_S, OP_B};
  endfunction

  function automatic logic [8:0] exp_strobes(input int st, input logic [6:0] op,
                                             input logic az, input logic rdy, input logic rst);
    logic req, we, asel, irw, pcw, psel, srcb, rw, m2r;
    req = 0; we = 0; asel = 0; irw = 0; pcw = 0; psel = 0; srcb = 0; rw = 0; m2r = 0;
    if (rst) begin
      if (st == 0) begin req = 1; irw = rdy; end
      if (st == 2) begin
        srcb = (op == OP_I) || (op == OP_L) || (op == OP_S);
        pcw  = (op == OP_B);
        psel = (op == OP_B) && az;
      end
      if (st == 3) begin req = 1; asel = 1; srcb = 1; we = (op == OP_S); pcw = rdy && (op == OP_S); end
      if (st == 4) begin rw = 1; m2r = (op == OP_L); pcw = 1; end
    end
    return {req, we, asel, irw, pcw, psel, srcb, rw, m2r};
  endfunction

  function automatic logic m_retire(input int st, input logic [6:0] op, input logic az,
                                    input logic rdy, input logic rst);
    logic [8:0] s;
    s = exp_strobes(st, op, az, rdy, rst);
    return s[4];
  endfunction

  function automatic int next_phase(input int st, input logic [6:0] op, input logic rdy);
    case (st)
      0: return rdy ? 1 : 0;
      1: return legal(op) ? 2 : 5;
      2: begin
        if (op == OP_R || op == OP_I) return 4;
        if (op == OP_L || op == OP_S) return 3;
        if (op == OP_B) return 0;
        return 5;
      end
      3: return rdy ? ((op == OP_L) ? 4 : 0) : 3;
      4: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic logic m_waiting(input int st, input logic rdy);
    return (st == 0 || st == 3) && !rdy;
  endfunction

  int          m_state = 0;
  int          m_wait = 0;
  logic [31:0] m_instret = 0;
  logic        m_ill = 0, m_bus = 0, m_valid = 0;
  int          preload_id = 0, seen_id = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset) begin
      m_state <= 0; m_wait <= 0; m_instret <= 0; m_ill <= 0; m_bus <= 0; m_valid <= 1;
    end else if (m_valid) begin
      if (preload_id != seen_id) begin
        m_instret <= PRELOAD;
        seen_id   <= preload_id;
      end else if (m_retire(m_state, opcode, alu_zero, mem_ready, reset)) begin
        m_instret <= m_instret + 1;
      end
      if (m_waiting(m_state, mem_ready) && (m_wait + 1 >= MW)) begin
        m_state <= 5; m_bus <= 1; m_wait <= 0;
      end else begin
        m_wait  <= m_waiting(m_state, mem_ready) ? m_wait + 1 : 0;
        m_state <= next_phase(m_state, opcode, mem_ready);
        if ((m_state == 1 || m_state == 2) && next_phase(m_state, opcode, mem_ready) == 5)
          m_ill <= 1;
      end
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int   pcw_cyc[$];
  logic pcw_sel[$];
  int   n_rw = 0, n_m2r = 0, n_req_pc = 0, n_req_alu = 0, n_any = 0;

  always begin
    @(negedge clk);
    if (m_valid) begin
      check("strobes", 32'(dut_vec), 32'(exp_strobes(m_state, opcode, alu_zero, mem_ready, reset)));
      check("state", 32'(state), 32'(m_state));
      check("instret", instret, m_instret);
      check("illegal", 32'(illegal), 32'(m_ill));
      check("bus_error", 32'(bus_error), 32'(m_bus));
    end
    if (pc_write === 1'b1) begin pcw_cyc.push_back(cyc); pcw_sel.push_back(pc_sel); end
    if (reg_write === 1'b1) n_rw++;
    if (mem_to_reg === 1'b1) n_m2r++;
    if (mem_req === 1'b1 && mem_addr_sel === 1'b0) n_req_pc++;
    if (mem_req === 1'b1 && mem_addr_sel === 1'b1) n_req_alu++;
    if (dut_vec !== 9'd0) n_any++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic az, input logic noise);
    opcode   = op;
    alu_zero = az;
    for (int i = 0; i <= fw; i++) tick(i == fw);
    tick(noise);
    if (!legal(op)) return;
    tick(noise);
    if (op == OP_L || op == OP_S)
      for (int i = 0; i <= mw; i++) tick(i == mw);
    if (op != OP_S && op != OP_B) tick(noise);
  endtask

  int seq_cyc[5] = '{4, 8, 13, 17, 20};

  initial begin
    int b, p0, rw0, m2r0, rq0, ra0, an0;
    @(posedge clk); #1;
    tick(0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_instret", instret, 32'd0);
    reset = 1'b1; #1;
    check("first_mem_req", 32'(mem_req), 32'd1);

    // Zero-wait ADDI, ADD, LW, SW, BEQ(taken)
    b = cyc; p0 = pcw_cyc.size();
    run_instr(OP_I, 0, 0, 0, 0);
    run_instr(OP_R, 0, 0, 0, 0);
    run_instr(OP_L, 0, 0, 0, 0);
    run_instr(OP_S, 0, 0, 0, 0);
    run_instr(OP_B, 0, 0, 1, 0);
    check("seq_pcw_count", 32'(pcw_cyc.size() - p0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (p0 + i < pcw_cyc.size()) check("seq_pcw_cycle", 32'(pcw_cyc[p0+i] - b + 1), 32'(seq_cyc[i]));
    if (p0 + 4 < pcw_cyc.size()) begin
      check("seq_addi_pc_sel", 32'(pcw_sel[p0]), 32'd0);
      check("seq_beq_pc_sel", 32'(pcw_sel[p0+4]), 32'd1);
    end
    check("seq_instret", instret, 32'd5);

    // LW with 3 fetch waits and 2 memory waits; stray mem_ready elsewhere
    b = cyc; p0 = pcw_cyc.size(); rw0 = n_rw; m2r0 = n_m2r; rq0 = n_req_pc; ra0 = n_req_alu;
    run_instr(OP_L, 3, 2, 0, 1);
    check("lw_pcw_count", 32'(pcw_cyc.size() - p0), 32'd1);
    if (p0 < pcw_cyc.size()) check("lw_total_cycles", 32'(pcw_cyc[p0] - b + 1), 32'd10);
    check("lw_reg_write_cycles", 32'(n_rw - rw0), 32'd1);
    check("lw_mem_to_reg_cycles", 32'(n_m2r - m2r0), 32'd1);
    check("lw_fetch_req_cycles", 32'(n_req_pc - rq0), 32'd4);
    check("lw_mem_req_cycles", 32'(n_req_alu - ra0), 32'd3);
    check("lw_instret", instret, 32'd6);

    // Unsupported opcode traps and stays quiet
    run_instr(7'h7F, 0, 0, 0, 0);
    check("ill_state", 32'(state), 32'd5);
    check("ill_flag", 32'(illegal), 32'd1);
    an0 = n_any;
    for (int i = 0; i < 20; i++) tick(1'(i % 2));
    check("ill_quiet_cycles", 32'(n_any - an0), 32'd0);
    check("ill_still_trap", 32'(state), 32'd5);
    reset = 1'b0;
    tick(0);
    check("ill_cleared", 32'(illegal), 32'd0);
    check("ill_reset_state", 32'(state), 32'd0);
    check("ill_reset_req", 32'(mem_req), 32'd0);
    check("ill_reset_instret", instret, 32'd0);
    reset = 1'b1; #1;
    check("ill_release_req", 32'(mem_req), 32'd1);

    // Watchdog: no mem_ready at all
    opcode = OP_I; rq0 = n_req_pc;
    for (int i = 0; i < 4; i++) tick(0);
    check("wd_state", 32'(state), 32'd5);
    check("wd_bus_error", 32'(bus_error), 32'd1);
    check("wd_req_dropped", 32'(mem_req), 32'd0);
    check("wd_req_cycles", 32'(n_req_pc - rq0), 32'd4);
    tick(1); tick(1);
    check("wd_stays_trap", 32'(state), 32'd5);
    reset = 1'b0;
    tick(0);
    check("wd_reset_clears", 32'(bus_error), 32'd0);
    reset = 1'b1; #1;

    // Watchdog: mem_ready on the last allowed wait cycle wins
    b = cyc; p0 = pcw_cyc.size();
    run_instr(OP_I, 3, 0, 0, 0);
    check("wd_edge_bus_error", 32'(bus_error), 32'd0);
    if (p0 < pcw_cyc.size()) check("wd_edge_cycles", 32'(pcw_cyc[p0] - b + 1), 32'd7);
    check("wd_edge_instret", instret, 32'd1);

    // instret wrap
    @(negedge clk); #1;
    force dut.instret = PRELOAD;
    #1;
    release dut.instret;
    preload_id++;
    @(posedge clk); #1;
    check("wrap_preload", instret, PRELOAD);
    run_instr(OP_B, 0, 0, 0, 0);
    check("wrap_to_zero", instret, 32'd0);

    // Reset in the middle of a STORE's memory wait
    run_instr(OP_I, 0, 0, 0, 0);
    opcode = OP_S;
    tick(1); tick(0); tick(0); tick(0);
    check("st_in_mem", 32'(state), 32'd3);
    p0 = pcw_cyc.size(); rw0 = n_rw;
    reset = 1'b0;
    tick(1);
    check("st_reset_req", 32'(mem_req), 32'd0);
    check("st_reset_we", 32'(mem_we), 32'd0);
    check("st_reset_state", 32'(state), 32'd0);
    check("st_reset_instret", instret, 32'd0);
    check("st_no_pc_write", 32'(pcw_cyc.size() - p0), 32'd0);
    check("st_no_reg_write", 32'(n_rw - rw0), 32'd0);
    reset = 1'b1; #1;
    check("st_release_req", 32'(mem_req), 32'd1);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
